// File: rtl/wb_write_queue_if.sv
// Write-back queue bus: ALU/load sources, register file write, forwarding.
// master = pipeline side driving results, slave = the write-back queue.
interface wb_write_queue_if #(
  parameter int WORD_LEN = 32,
  parameter int ADDR_LEN = 4,
  parameter int DEPTH    = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic                alu_wb_en;
  logic [ADDR_LEN-1:0] alu_dest;
  logic [WORD_LEN-1:0] alu_value;
  logic                ld_valid;
  logic [ADDR_LEN-1:0] ld_dest;
  logic [WORD_LEN-1:0] ld_value;
  logic                ld_ready;
  logic                stall_out;
  logic                rf_we;
  logic [ADDR_LEN-1:0] rf_dest;
  logic [WORD_LEN-1:0] rf_wdata;
  logic [ADDR_LEN-1:0] fwd_addr_1;
  logic [ADDR_LEN-1:0] fwd_addr_2;
  logic                fwd_hit_1;
  logic                fwd_hit_2;
  logic [WORD_LEN-1:0] fwd_val_1;
  logic [WORD_LEN-1:0] fwd_val_2;
  logic [CW-1:0]       pending_cnt;

  modport master (
    output alu_wb_en, alu_dest, alu_value,
    output ld_valid, ld_dest, ld_value,
    output fwd_addr_1, fwd_addr_2,
    input  ld_ready, stall_out,
    input  rf_we, rf_dest, rf_wdata,
    input  fwd_hit_1, fwd_hit_2,
    input  fwd_val_1, fwd_val_2,
    input  pending_cnt
  );

  modport slave (
    input  alu_wb_en, alu_dest, alu_value,
    input  ld_valid, ld_dest, ld_value,
    input  fwd_addr_1, fwd_addr_2,
    output ld_ready, stall_out,
    output rf_we, rf_dest, rf_wdata,
    output fwd_hit_1, fwd_hit_2,
    output fwd_val_1, fwd_val_2,
    output pending_cnt
  );
endinterface

// File: rtl/wb_write_queue.sv
// Write-back stage: merges ALU and load results into one registered RF write
// per cycle, queues deferred writes in order, forwards queued values to decode.
// Ports: clk, rst (sync, active-high), bus (wb_write_queue_if.slave).
module wb_write_queue #(
  parameter int WORD_LEN = 32,
  parameter int ADDR_LEN = 4,
  parameter int DEPTH    = 4
) (
  input logic             clk,
  input logic             rst,
  wb_write_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_LEN-1:0] mem_dest_q [DEPTH];
  logic [WORD_LEN-1:0] mem_val_q  [DEPTH];
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                rf_we_q, rf_we_d;
  logic [ADDR_LEN-1:0] rf_dest_q, rf_dest_d;
  logic [WORD_LEN-1:0] rf_wdata_q, rf_wdata_d;

  logic                stall;
  logic                ld_rdy;
  logic                alu_acc;
  logic                ld_acc;
  logic                empty;

  logic                deq;
  logic                enq_ld;
  logic                enq_alu;
  logic [1:0]          n_enq;
  logic                wr0;
  logic                wr1;
  logic [ADDR_LEN-1:0] wr0_dest;
  logic [WORD_LEN-1:0] wr0_val;

  logic                com_v;
  logic [ADDR_LEN-1:0] com_dest;
  logic [WORD_LEN-1:0] com_val;

  logic                hit1, hit2;
  logic [WORD_LEN-1:0] val1, val2;

  // Thresholds leave room for a worst-case dual enqueue.
  assign stall   = cnt_q >= CW'(DEPTH - 1);
  assign ld_rdy  = cnt_q <= CW'(DEPTH - 2);
  assign alu_acc = bus.alu_wb_en & ~stall;
  assign ld_acc  = bus.ld_valid & ld_rdy;
  assign empty   = cnt_q == '0;

  // The oldest candidate commits; the load is older than
  // a same-cycle ALU result.
  always_comb begin
    deq      = 1'b0;
    enq_ld   = 1'b0;
    enq_alu  = 1'b0;
    com_v    = 1'b0;
    com_dest = '0;
    com_val  = '0;
    unique case (1'b1)
      !empty: begin
        deq      = 1'b1;
        com_v    = 1'b1;
        com_dest = mem_dest_q[head_q];
        com_val  = mem_val_q[head_q];
        enq_ld   = ld_acc;
        enq_alu  = alu_acc;
      end
      empty && ld_acc: begin
        com_v    = 1'b1;
        com_dest = bus.ld_dest;
        com_val  = bus.ld_value;
        enq_alu  = alu_acc;
      end
      empty && !ld_acc && alu_acc: begin
        com_v    = 1'b1;
        com_dest = bus.alu_dest;
        com_val  = bus.alu_value;
      end
      default: begin
        com_v = 1'b0;
      end
    endcase
  end

  // Slot tail gets the older enqueued item, tail+1 the ALU
  // result when both are enqueued.
  always_comb begin
    n_enq    = {1'b0, enq_ld} + {1'b0, enq_alu};
    wr0      = enq_ld | enq_alu;
    wr1      = enq_ld & enq_alu;
    wr0_dest = enq_ld ? bus.ld_dest  : bus.alu_dest;
    wr0_val  = enq_ld ? bus.ld_value : bus.alu_value;
  end

  always_comb begin
    head_d = head_q + PW'(deq);
    tail_d = tail_q + PW'(n_enq);
    cnt_d  = cnt_q + CW'(n_enq) - CW'(deq);
  end

  // Idle cycles drop rf_we but keep the last address/data.
  always_comb begin
    rf_we_d    = com_v;
    rf_dest_d  = com_v ? com_dest : rf_dest_q;
    rf_wdata_d = com_v ? com_val  : rf_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_dest_q  <= '0;
      rf_wdata_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      rf_we_q    <= rf_we_d;
      rf_dest_q  <= rf_dest_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Storage needs no reset: occupancy alone marks entries valid.
  always_ff @(posedge clk) begin
    if (!rst && wr0) begin
      mem_dest_q[tail_q] <= wr0_dest;
      mem_val_q[tail_q]  <= wr0_val;
    end
    if (!rst && wr1) begin
      mem_dest_q[tail_q + PW'(1)] <= bus.alu_dest;
      mem_val_q[tail_q + PW'(1)]  <= bus.alu_value;
    end
  end

  // Scan oldest to newest so the newest match wins.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    val1 = '0;
    val2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt_q) begin
        if (mem_dest_q[head_q + PW'(i)] == bus.fwd_addr_1) begin
          hit1 = 1'b1;
          val1 = mem_val_q[head_q + PW'(i)];
        end
        if (mem_dest_q[head_q + PW'(i)] == bus.fwd_addr_2) begin
          hit2 = 1'b1;
          val2 = mem_val_q[head_q + PW'(i)];
        end
      end
    end
  end

  assign bus.stall_out   = stall;
  assign bus.ld_ready    = ld_rdy;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_dest     = rf_dest_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.fwd_hit_1   = hit1;
  assign bus.fwd_hit_2   = hit2;
  assign bus.fwd_val_1   = val1;
  assign bus.fwd_val_2   = val2;
  assign bus.pending_cnt = cnt_q;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    (n_enq != 2'd0) |-> (cnt_q != CW'(DEPTH - 1))
  );
endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed scenarios, then random
// traffic against a queue model of "oldest pending write commits first".
module tb_wb_write_queue;
  localparam int W     = 32;
  localparam int A     = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [A-1:0] d;
    logic [W-1:0] v;
  } ent_t;

  logic clk;
  logic rst;

  wb_write_queue_if #(.WORD_LEN(W), .ADDR_LEN(A), .DEPTH(DEPTH)) bus ();

  wb_write_queue #(.WORD_LEN(W), .ADDR_LEN(A), .DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  ent_t         dq[$];
  logic         exp_we;
  logic [A-1:0] exp_dest;
  logic [W-1:0] exp_wdata;
  logic [W-1:0] ref_img [16];
  logic [W-1:0] dut_img [16];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mfwd(input logic [A-1:0] a, output logic h,
                      output logic [W-1:0] v);
    h = 1'b0;
    v = '0;
    for (int i = dq.size() - 1; i >= 0; i--) begin
      if (dq[i].d == a) begin
        h = 1'b1;
        v = dq[i].v;
        break;
      end
    end
  endtask

  // One clock: drive at negedge, check combinational outputs,
  // then check registered outputs just after posedge.
  task automatic cyc(input logic av, input logic [A-1:0] ad,
                     input logic [W-1:0] aval, input logic lv,
                     input logic [A-1:0] ldd, input logic [W-1:0] lval,
                     input logic [A-1:0] f1, input logic [A-1:0] f2,
                     input logic r);
    logic h1, h2;
    logic [W-1:0] v1, v2;
    bit aacc, lacc;
    ent_t e;
    rst = r;
    bus.alu_wb_en  = av;
    bus.alu_dest   = ad;
    bus.alu_value  = aval;
    bus.ld_valid   = lv;
    bus.ld_dest    = ldd;
    bus.ld_value   = lval;
    bus.fwd_addr_1 = f1;
    bus.fwd_addr_2 = f2;
    #1;
    lacc = lv && (dq.size() <= DEPTH - 2);
    aacc = av && (dq.size() <  DEPTH - 1);
    if (!r) begin
      mfwd(f1, h1, v1);
      mfwd(f2, h2, v2);
      chk("stall_out", bus.stall_out, dq.size() >= DEPTH - 1);
      chk("ld_ready", bus.ld_ready, dq.size() <= DEPTH - 2);
      chk("cnt_pre", bus.pending_cnt, dq.size());
      chk("fwd_hit_1", bus.fwd_hit_1, h1);
      chk("fwd_val_1", bus.fwd_val_1, v1);
      chk("fwd_hit_2", bus.fwd_hit_2, h2);
      chk("fwd_val_2", bus.fwd_val_2, v2);
    end
    @(posedge clk);
    #1;
    if (r) begin
      dq.delete();
      exp_we    = 1'b0;
      exp_dest  = '0;
      exp_wdata = '0;
    end else begin
      if (lacc) begin
        e.d = ldd;
        e.v = lval;
        dq.push_back(e);
      end
      if (aacc) begin
        e.d = ad;
        e.v = aval;
        dq.push_back(e);
      end
      if (dq.size() > 0) begin
        e = dq.pop_front();
        exp_we    = 1'b1;
        exp_dest  = e.d;
        exp_wdata = e.v;
        ref_img[e.d] = e.v;
      end else begin
        exp_we = 1'b0;
      end
    end
    chk("rf_we", bus.rf_we, exp_we);
    chk("rf_dest", bus.rf_dest, exp_dest);
    chk("rf_wdata", bus.rf_wdata, exp_wdata);
    chk("cnt_post", bus.pending_cnt, dq.size());
    if (bus.rf_we === 1'b1) dut_img[bus.rf_dest] = bus.rf_wdata;
    @(negedge clk);
  endtask

  task automatic idle(input logic [A-1:0] f1, input logic [A-1:0] f2);
    cyc(1'b0, '0, '0, 1'b0, '0, '0, f1, f2, 1'b0);
  endtask

  task automatic dual(input logic [A-1:0] ld, input logic [W-1:0] lv,
                      input logic [A-1:0] ad, input logic [W-1:0] av);
    cyc(1'b1, ad, av, 1'b1, ld, lv, ld, ad, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_we      = 1'b0;
    exp_dest    = '0;
    exp_wdata   = '0;
    for (int i = 0; i < 16; i++) begin
      ref_img[i] = '0;
      dut_img[i] = '0;
    end
    rst = 1'b1;
    bus.alu_wb_en  = 1'b0;
    bus.alu_dest   = '0;
    bus.alu_value  = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_dest    = '0;
    bus.ld_value   = '0;
    bus.fwd_addr_1 = '0;
    bus.fwd_addr_2 = '0;
    @(negedge clk);

    // Reset state
    cyc(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, 1'b1);

    // ALU bypass
    cyc(1'b1, 4'd3, 32'hA5, 1'b0, '0, '0, 4'd3, 4'd0, 1'b0);
    idle(4'd3, 4'd0);

    // Same-cycle load and ALU to one dest
    dual(4'd5, 32'h11, 4'd5, 32'h22);
    idle(4'd5, 4'd1);
    idle(4'd5, 4'd1);

    // Back-to-back dual arrivals fill to the thresholds
    dual(4'd1, 32'h101, 4'd2, 32'h102);
    dual(4'd3, 32'h103, 4'd4, 32'h104);
    dual(4'd5, 32'h105, 4'd6, 32'h106);
    dual(4'd7, 32'h107, 4'd8, 32'h108);
    for (int i = 0; i < 4; i++) idle(4'd6, 4'd4);

    // Two queued writes to dest 7
    dual(4'd1, 32'h201, 4'd2, 32'h202);
    dual(4'd7, 32'h1, 4'd7, 32'h2);
    idle(4'd7, 4'd2);
    for (int i = 0; i < 3; i++) idle(4'd7, 4'd0);

    // Reset with three entries queued; arrivals then dropped
    dual(4'd9, 32'h301, 4'd10, 32'h302);
    dual(4'd11, 32'h303, 4'd12, 32'h304);
    dual(4'd13, 32'h305, 4'd14, 32'h306);
    cyc(1'b1, 4'd15, 32'h3FF, 1'b1, 4'd15, 32'h3FE, '0, '0, 1'b1);
    idle(4'd13, 4'd15);
    for (int i = 0; i < 16; i++) begin
      ref_img[i] = '0;
      dut_img[i] = '0;
    end

    // Commit, then idle cycles hold address/data
    cyc(1'b1, 4'd6, 32'hBEEF, 1'b0, '0, '0, '0, '0, 1'b0);
    idle(4'd6, 4'd0);
    idle(4'd6, 4'd0);

    // Random stress
    for (int n = 0; n < 600; n++) begin
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
    end
    for (int i = 0; i < 6; i++) idle('0, '0);
    for (int i = 0; i < 16; i++) chk("reg_image", dut_img[i], ref_img[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end
endmodule
